// File: rtl/sseg_display_arbiter.sv
// Purpose: shares a 4-digit seven-segment display between requesters A and B with min-dwell / max-hold rotation.
// Latency: req to gnt in 1 clock; owner data to hex registers in 1 clock (first-cycle load on grant).
// Backpressure: none; requests are levels held by the requesters, grants are the only handshake.
module sseg_display_arbiter #(
    parameter int unsigned TICK_DIV    = 100000,
    parameter int unsigned TICK_WIDTH  = 17,
    parameter int unsigned DWELL_WIDTH = 12,
    parameter int unsigned MIN_DWELL   = 500,
    parameter int unsigned MAX_HOLD    = 2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_a,
    input  logic [15:0] data_a,
    input  logic        req_b,
    input  logic [15:0] data_b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic [3:0]  hex0,
    output logic [3:0]  hex1,
    output logic [3:0]  hex2,
    output logic [3:0]  hex3,
    output logic        disp_en
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_A = 2'd1,
        ST_OWN_B = 2'd2
    } state_t;

    localparam logic [TICK_WIDTH-1:0]  TICK_LAST = TICK_WIDTH'(TICK_DIV - 1);
    localparam logic [DWELL_WIDTH-1:0] DWELL_MIN = DWELL_WIDTH'(MIN_DWELL);
    localparam logic [DWELL_WIDTH-1:0] DWELL_MAX = DWELL_WIDTH'(MAX_HOLD);

    state_t                  state_q, state_d;
    logic [TICK_WIDTH-1:0]   presc_q, presc_d;
    logic [DWELL_WIDTH-1:0]  dwell_q, dwell_d;
    logic                    last_b_q, last_b_d;   // 1: B was served last, so A wins the next tie
    logic                    fresh_q, fresh_d;     // first cycle of a new ownership
    logic [15:0]             hex_q, hex_d;
    logic                    tick;

    logic                    own_req;
    logic                    oth_req;
    logic [15:0]             own_data;
    state_t                  oth_state;

    // Free-running prescaler; never disturbed by grant changes.
    always_comb begin
        tick    = (presc_q == TICK_LAST);
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    // View of the current owner and its competitor, so both OWN states share one release rule.
    always_comb begin
        own_req   = req_a;
        oth_req   = req_b;
        own_data  = data_a;
        oth_state = ST_OWN_B;
        if (state_q == ST_OWN_B) begin
            own_req   = req_b;
            oth_req   = req_a;
            own_data  = data_b;
            oth_state = ST_OWN_A;
        end
    end

    // Next-state, dwell, fairness and display-data logic.
    always_comb begin
        state_d  = state_q;
        dwell_d  = dwell_q;
        last_b_d = last_b_q;
        fresh_d  = 1'b0;
        hex_d    = hex_q;

        case (state_q)
            ST_IDLE: begin
                hex_d   = '0;
                dwell_d = '0;
                if (req_a && (!req_b || last_b_q)) begin
                    state_d  = ST_OWN_A;
                    last_b_d = 1'b0;
                    fresh_d  = 1'b1;
                end else if (req_b) begin
                    state_d  = ST_OWN_B;
                    last_b_d = 1'b1;
                    fresh_d  = 1'b1;
                end
            end

            ST_OWN_A, ST_OWN_B: begin
                // Saturating dwell so a lone long-term owner never wraps back under MIN_DWELL.
                if (tick && (dwell_q < DWELL_MAX)) begin
                    dwell_d = dwell_q + 1'b1;
                end
                // Live update while requesting; always load once on entry so the new owner shows.
                if (own_req || fresh_q) begin
                    hex_d = own_data;
                end

                if (!own_req && (dwell_q >= DWELL_MIN)) begin
                    if (oth_req) begin
                        state_d  = oth_state;
                        dwell_d  = '0;
                        last_b_d = (oth_state == ST_OWN_B);
                        fresh_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        dwell_d = '0;
                        hex_d   = '0;
                    end
                end else if (own_req && oth_req && (dwell_q >= DWELL_MAX)) begin
                    state_d  = oth_state;
                    dwell_d  = '0;
                    last_b_d = (oth_state == ST_OWN_B);
                    fresh_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                dwell_d = '0;
                hex_d   = '0;
            end
        endcase
    end

    // State and datapath registers; reset drops ownership immediately with no handover.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            presc_q  <= '0;
            dwell_q  <= '0;
            last_b_q <= 1'b1;
            fresh_q  <= 1'b0;
            hex_q    <= '0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            dwell_q  <= dwell_d;
            last_b_q <= last_b_d;
            fresh_q  <= fresh_d;
            hex_q    <= hex_d;
        end
    end

    assign gnt_a   = (state_q == ST_OWN_A);
    assign gnt_b   = (state_q == ST_OWN_B);
    assign disp_en = gnt_a | gnt_b;
    assign hex0    = hex_q[3:0];
    assign hex1    = hex_q[7:4];
    assign hex2    = hex_q[11:8];
    assign hex3    = hex_q[15:12];

endmodule

// File: tb/tb_sseg_display_arbiter.sv
// Purpose: self-checking bench for sseg_display_arbiter with a time-stamped expectation queue.
// Latency: expectations are tagged with the clock edge (counted from reset release) they apply to.
// Backpressure: not applicable; requests are driven as levels.
module tb_sseg_display_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req_a;
    logic [15:0] data_a;
    logic        req_b;
    logic [15:0] data_b;
    logic        gnt_a;
    logic        gnt_b;
    logic [3:0]  hex0;
    logic [3:0]  hex1;
    logic [3:0]  hex2;
    logic [3:0]  hex3;
    logic        disp_en;

    int n_total = 0;
    int n_bad   = 0;
    int edge_n;

    typedef struct {
        string       tag;
        int          at;
        logic        ga;
        logic        gb;
        logic [15:0] hex;
    } exp_t;

    exp_t sb_q[$];

    sseg_display_arbiter #(
        .TICK_DIV   (4),
        .TICK_WIDTH (3),
        .DWELL_WIDTH(12),
        .MIN_DWELL  (3),
        .MAX_HOLD   (6)
    ) dut (
        .clk    (clk),
        .reset  (rst_n),
        .req_a  (req_a),
        .data_a (data_a),
        .req_b  (req_b),
        .data_b (data_b),
        .gnt_a  (gnt_a),
        .gnt_b  (gnt_b),
        .hex0   (hex0),
        .hex1   (hex1),
        .hex2   (hex2),
        .hex3   (hex3),
        .disp_en(disp_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge index since reset release; with TICK_DIV=4 the prescaler ticks into edges 4, 8, 12, ...
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_at(input string tag, input int at, input logic ga, input logic gb,
                             input logic [15:0] hex);
        exp_t e;
        e.tag = tag;
        e.at  = at;
        e.ga  = ga;
        e.gb  = gb;
        e.hex = hex;
        sb_q.push_back(e);
    endtask

    task automatic expect_span(input string tag, input int from, input int to, input logic ga,
                               input logic gb, input logic [15:0] hex);
        for (int k = from; k <= to; k++) expect_at(tag, k, ga, gb, hex);
    endtask

    // Scoreboard: compare every expectation due at this edge, flag any that slipped past.
    always @(negedge clk) begin
        int i;
        exp_t e;
        if (rst_n) begin
            i = 0;
            while (i < sb_q.size()) begin
                e = sb_q[i];
                if (e.at == edge_n) begin
                    chk($sformatf("%s@%0d gnt_a", e.tag, e.at), 32'(gnt_a), 32'(e.ga));
                    chk($sformatf("%s@%0d gnt_b", e.tag, e.at), 32'(gnt_b), 32'(e.gb));
                    chk($sformatf("%s@%0d disp_en", e.tag, e.at), 32'(disp_en), 32'(e.ga | e.gb));
                    chk($sformatf("%s@%0d hex", e.tag, e.at), 32'({hex3, hex2, hex1, hex0}),
                        32'(e.hex));
                    sb_q.delete(i);
                end else if (e.at < edge_n) begin
                    chk($sformatf("%s missed", e.tag), 32'(edge_n), 32'(e.at));
                    sb_q.delete(i);
                end else begin
                    i++;
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic goto_edge(input int k);
        int guard = 0;
        while (edge_n < k && guard < 1000) begin
            step();
            guard++;
        end
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while (sb_q.size() != 0 && k < 200) begin
            step();
            k++;
        end
        chk({tag, " drain"}, 32'(sb_q.size()), 32'd0);
    endtask

    // Leaves the bench just after a posedge with reset released and edge_n == 0.
    task automatic do_reset();
        rst_n  = 1'b0;
        req_a  = 1'b0;
        req_b  = 1'b0;
        data_a = 16'h0;
        data_b = 16'h0;
        step(2);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        req_a  = 1'b0;
        req_b  = 1'b0;
        data_a = 16'h0;
        data_b = 16'h0;
        #1;
        chk("rst gnt_a", 32'(gnt_a), 32'd0);
        chk("rst gnt_b", 32'(gnt_b), 32'd0);
        chk("rst disp_en", 32'(disp_en), 32'd0);
        chk("rst hex", 32'({hex3, hex2, hex1, hex0}), 32'd0);

        // Grant, preemption at dwell 6 (ticks 4..24 -> switch at edge 25), release, tie to A.
        do_reset();
        req_a  = 1'b1;
        data_a = 16'h1234;
        expect_at  ("grant", 1, 1'b1, 1'b0, 16'h0000);
        expect_span("own_a", 2, 24, 1'b1, 1'b0, 16'h1234);
        expect_at  ("preempt", 25, 1'b0, 1'b1, 16'h1234);
        expect_at  ("b_data", 26, 1'b0, 1'b1, 16'h5678);
        expect_span("own_b", 27, 36, 1'b0, 1'b1, 16'h5678);
        expect_span("b_idle", 37, 38, 1'b0, 1'b0, 16'h0000);
        expect_at  ("tie_a", 39, 1'b1, 1'b0, 16'h0000);
        expect_at  ("tie_a_hex", 40, 1'b1, 1'b0, 16'h1234);
        goto_edge(2);
        req_b  = 1'b1;
        data_b = 16'h5678;
        goto_edge(26);
        req_a = 1'b0;
        req_b = 1'b0;
        goto_edge(38);
        req_a = 1'b1;
        req_b = 1'b1;
        drain("preempt");

        // Simultaneous requests from reset: A first, B takes over directly when A drops.
        do_reset();
        req_a  = 1'b1;
        data_a = 16'h1111;
        req_b  = 1'b1;
        data_b = 16'h2222;
        expect_at  ("tie0", 1, 1'b1, 1'b0, 16'h0000);
        expect_span("tie0_a", 2, 14, 1'b1, 1'b0, 16'h1111);
        expect_at  ("handover", 15, 1'b0, 1'b1, 16'h1111);
        expect_span("handover_b", 16, 18, 1'b0, 1'b1, 16'h2222);
        goto_edge(14);
        req_a = 1'b0;
        drain("handover");

        // Early drop after one tick: ownership and frozen digits kept until dwell 3 (edge 13).
        do_reset();
        req_a  = 1'b1;
        data_a = 16'hABCD;
        expect_at  ("early", 1, 1'b1, 1'b0, 16'h0000);
        expect_span("early_hold", 2, 12, 1'b1, 1'b0, 16'hABCD);
        expect_span("early_idle", 13, 15, 1'b0, 1'b0, 16'h0000);
        goto_edge(4);
        req_a  = 1'b0;
        data_a = 16'h9999;
        drain("early");

        // Lone owner for 20+ ticks, live data, then an immediate preempt from saturated dwell.
        do_reset();
        req_a  = 1'b1;
        data_a = 16'h0001;
        expect_at  ("solo", 1, 1'b1, 1'b0, 16'h0000);
        expect_span("solo_1", 2, 40, 1'b1, 1'b0, 16'h0001);
        expect_span("solo_2", 41, 85, 1'b1, 1'b0, 16'h0002);
        expect_at  ("sat_preempt", 86, 1'b0, 1'b1, 16'h0002);
        expect_at  ("sat_b", 87, 1'b0, 1'b1, 16'hBEEF);
        goto_edge(40);
        data_a = 16'h0002;
        goto_edge(85);
        req_b  = 1'b1;
        data_b = 16'hBEEF;
        drain("solo");

        // Reset mid-ownership of B clears outputs without a clock edge.
        goto_edge(90);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst gnt_a", 32'(gnt_a), 32'd0);
        chk("arst gnt_b", 32'(gnt_b), 32'd0);
        chk("arst disp_en", 32'(disp_en), 32'd0);
        chk("arst hex", 32'({hex3, hex2, hex1, hex0}), 32'd0);
        do_reset();
        req_a  = 1'b1;
        data_a = 16'h7777;
        req_b  = 1'b1;
        data_b = 16'h8888;
        expect_at("post_rst", 1, 1'b1, 1'b0, 16'h0000);
        expect_at("post_rst_hex", 2, 1'b1, 1'b0, 16'h7777);
        drain("post_rst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
